// File: rtl/mem_port_sequencer.sv
// Shared single-port data-memory sequencer for the gpp_calc core.
// Arbitrates fetch, load/store and stack requesters with fixed priority
// (stack > ls > fetch) plus a fetch anti-starvation override. Sequences
// multi-cycle reads and owns the stack pointer with depth checking.
module mem_port_sequencer #(
  parameter int unsigned     AW          = 16,
  parameter int unsigned     DW          = 16,
  parameter int unsigned     MEM_LAT     = 1,
  parameter logic [AW-1:0]   STACK_BASE  = 16'hFFFF,
  parameter int unsigned     STACK_DEPTH = 64,
  parameter int unsigned     STARVE_LIM  = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // Instruction fetch
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  // Load/store
  input  logic          ls_req_i,
  input  logic          ls_we_i,
  input  logic [AW-1:0] ls_addr_i,
  input  logic [DW-1:0] ls_wdata_i,
  output logic          ls_gnt_o,
  output logic          ls_rvalid_o,
  output logic [DW-1:0] ls_rdata_o,
  // Stack push/pop
  input  logic          stk_req_i,
  input  logic          stk_pop_i,
  input  logic [DW-1:0] stk_wdata_i,
  output logic          stk_gnt_o,
  output logic          stk_rvalid_o,
  output logic          stk_err_o,
  output logic [DW-1:0] stk_rdata_o,
  output logic [AW-1:0] sp_o,
  // Memory macro
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int unsigned     CntW     = 2;  // enough for MEM_LAT up to 4
  localparam int unsigned     StvW     = $clog2(STARVE_LIM + 1);
  localparam logic [CntW-1:0] LatLoad  = CntW'(MEM_LAT - 1);
  localparam logic [StvW-1:0] StvMax   = StvW'(STARVE_LIM);
  localparam logic [AW-1:0]   DepthMax = AW'(STACK_DEPTH);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;
  typedef enum logic [1:0] {TagNone, TagIf, TagLs, TagStk} tag_e;

  state_e          state_q, state_d;
  tag_e            tag_q, tag_d;
  tag_e            win;
  logic            pend_q, pend_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [StvW-1:0] starve_q, starve_d;
  logic [AW-1:0]   sp_q, sp_d;
  logic [AW-1:0]   depth;
  logic            arb_open;
  logic            rd_grant;
  logic            rd_done;

  // Pick the winner; gated by reset so every grant drops as soon as reset asserts.
  always_comb begin
    arb_open = rst_ni && ((state_q == StIdle) || (cnt_q == '0));
    depth    = STACK_BASE - sp_q;
    win      = TagNone;
    if (arb_open) begin
      if (if_req_i && (starve_q == StvMax)) begin
        win = TagIf;
      end else if (stk_req_i) begin
        win = TagStk;
      end else if (ls_req_i) begin
        win = TagLs;
      end else if (if_req_i) begin
        win = TagIf;
      end
    end
  end

  // Drive grants and the memory port from the winner; stack errors grant but skip memory.
  always_comb begin
    if_gnt_o    = 1'b0;
    ls_gnt_o    = 1'b0;
    stk_gnt_o   = 1'b0;
    stk_err_o   = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rd_grant    = 1'b0;
    sp_d        = sp_q;
    unique case (win)
      TagIf: begin
        if_gnt_o   = 1'b1;
        mem_en_o   = 1'b1;
        mem_addr_o = if_addr_i;
        rd_grant   = 1'b1;
      end
      TagLs: begin
        ls_gnt_o    = 1'b1;
        mem_en_o    = 1'b1;
        mem_we_o    = ls_we_i;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = ls_wdata_i;
        rd_grant    = ~ls_we_i;
      end
      TagStk: begin
        stk_gnt_o = 1'b1;
        if (stk_pop_i) begin
          if (depth == '0) begin
            stk_err_o = 1'b1;
          end else begin
            mem_en_o   = 1'b1;
            mem_addr_o = sp_q;
            rd_grant   = 1'b1;
            sp_d       = sp_q + AW'(1);
          end
        end else begin
          if (depth == DepthMax) begin
            stk_err_o = 1'b1;
          end else begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = sp_q - AW'(1);
            mem_wdata_o = stk_wdata_i;
            sp_d        = sp_q - AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Read tracking: pending flag plus latency down-counter; BUSY only when MEM_LAT > 1.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    if (pend_q) begin
      if (cnt_q == '0) begin
        pend_d  = 1'b0;
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
    if (rd_grant) begin
      pend_d  = 1'b1;
      tag_d   = win;
      cnt_d   = LatLoad;
      state_d = (MEM_LAT > 1) ? StBusy : StIdle;
    end
  end

  // Starvation counter: counts arbitration losses while fetch is requesting.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i) begin
      starve_d = '0;
    end else if (arb_open) begin
      starve_d = (win == TagIf) ? '0 : starve_q + StvW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      tag_q    <= TagNone;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      starve_q <= '0;
      sp_q     <= STACK_BASE;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      sp_q     <= sp_d;
    end
  end

  // Return read data to the requester whose read completes this cycle.
  always_comb begin
    rd_done      = pend_q && (cnt_q == '0);
    if_rvalid_o  = rd_done && (tag_q == TagIf);
    ls_rvalid_o  = rd_done && (tag_q == TagLs);
    stk_rvalid_o = rd_done && (tag_q == TagStk);
    if_rdata_o   = if_rvalid_o  ? mem_rdata_i : '0;
    ls_rdata_o   = ls_rvalid_o  ? mem_rdata_i : '0;
    stk_rdata_o  = stk_rvalid_o ? mem_rdata_i : '0;
    sp_o         = sp_q;
  end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: instance A uses MEM_LAT=2,
// instance B uses MEM_LAT=1; both share stimulus and have their own memory model.
module tb_mem_port_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_we, stk_req, stk_pop;
  logic [15:0] if_addr, ls_addr, ls_wdata, stk_wdata;

  logic        a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid;
  logic        a_stk_gnt, a_stk_rvalid, a_stk_err, a_mem_en, a_mem_we;
  logic [15:0] a_if_rdata, a_ls_rdata, a_stk_rdata, a_sp, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid;
  logic        b_stk_gnt, b_stk_rvalid, b_stk_err, b_mem_en, b_mem_we;
  logic [15:0] b_if_rdata, b_ls_rdata, b_stk_rdata, b_sp, b_mem_addr, b_mem_wdata, b_mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_sequencer #(.MEM_LAT(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(a_if_gnt), .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(a_ls_gnt), .ls_rvalid_o(a_ls_rvalid), .ls_rdata_o(a_ls_rdata),
    .stk_req_i(stk_req), .stk_pop_i(stk_pop), .stk_wdata_i(stk_wdata),
    .stk_gnt_o(a_stk_gnt), .stk_rvalid_o(a_stk_rvalid), .stk_err_o(a_stk_err),
    .stk_rdata_o(a_stk_rdata), .sp_o(a_sp),
    .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
  );

  mem_port_sequencer #(.MEM_LAT(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(b_if_gnt), .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(b_ls_gnt), .ls_rvalid_o(b_ls_rvalid), .ls_rdata_o(b_ls_rdata),
    .stk_req_i(stk_req), .stk_pop_i(stk_pop), .stk_wdata_i(stk_wdata),
    .stk_gnt_o(b_stk_gnt), .stk_rvalid_o(b_stk_rvalid), .stk_err_o(b_stk_err),
    .stk_rdata_o(b_stk_rdata), .sp_o(b_sp),
    .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  // Memory models: synchronous write, read data delayed by MEM_LAT edges.
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] a_rd1, a_rd2, b_rd1;

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    a_rd1 <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr] : 16'h0000;
    a_rd2 <= a_rd1;
    if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
    b_rd1 <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : 16'h0000;
  end
  assign a_mem_rdata = a_rd2;
  assign b_mem_rdata = b_rd1;

  task automatic idle_inputs();
    if_req = 0; ls_req = 0; ls_we = 0; stk_req = 0; stk_pop = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0; stk_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0; idle_inputs();
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs();
    @(negedge clk); #1;
    total++; if (a_sp !== 16'hFFFF) begin bad++; $display("FAIL rst_sp: got %h want ffff", a_sp); end
    total++; if ({a_if_gnt, a_ls_gnt, a_stk_gnt, a_mem_en, a_mem_we, a_stk_err} !== 6'b0) begin
      bad++; $display("FAIL rst_ctrl: got %b want 000000",
                      {a_if_gnt, a_ls_gnt, a_stk_gnt, a_mem_en, a_mem_we, a_stk_err}); end
    total++; if ({a_mem_addr, a_mem_wdata, a_if_rdata} !== 48'h0) begin
      bad++; $display("FAIL rst_data: got %h want 0", {a_mem_addr, a_mem_wdata, a_if_rdata}); end
    @(negedge clk); rst_n = 1;
  endtask

  // Preload via stores, then a single fetch with MEM_LAT=2 followed by a load.
  task automatic test_store_fetch();
    @(negedge clk); ls_req = 1; ls_we = 1; ls_addr = 16'h0010; ls_wdata = 16'hBEEF; #1;
    total++; if ({a_ls_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {3'b111, 32'h0010BEEF}) begin
      bad++; $display("FAIL store_port: got %b %h %h", {a_ls_gnt, a_mem_en, a_mem_we}, a_mem_addr, a_mem_wdata); end
    @(negedge clk); ls_addr = 16'h0020; ls_wdata = 16'h5A5A;
    @(negedge clk); ls_req = 0; ls_we = 0; if_req = 1; if_addr = 16'h0010; #1;
    total++; if ({a_if_gnt, a_mem_en, a_mem_we, a_mem_addr} !== {3'b110, 16'h0010}) begin
      bad++; $display("FAIL fetch_gnt: got %b %h want 110 0010", {a_if_gnt, a_mem_en, a_mem_we}, a_mem_addr); end
    @(negedge clk); if_req = 0; ls_req = 1; ls_we = 0; ls_addr = 16'h0020; #1;
    total++; if ({a_ls_gnt, a_mem_en, a_if_rvalid} !== 3'b000) begin
      bad++; $display("FAIL busy_nogrant: got %b want 000", {a_ls_gnt, a_mem_en, a_if_rvalid}); end
    @(negedge clk); #1;
    total++; if ({a_if_rvalid, a_if_rdata} !== {1'b1, 16'hBEEF}) begin
      bad++; $display("FAIL fetch_rdata: got %b %h want 1 beef", a_if_rvalid, a_if_rdata); end
    total++; if ({a_ls_gnt, a_mem_addr} !== {1'b1, 16'h0020}) begin
      bad++; $display("FAIL grant_at_lat: got %b %h want 1 0020", a_ls_gnt, a_mem_addr); end
    @(negedge clk); ls_req = 0; #1;
    total++; if ({a_ls_rvalid, a_if_rvalid} !== 2'b00) begin
      bad++; $display("FAIL load_early: got %b want 00", {a_ls_rvalid, a_if_rvalid}); end
    @(negedge clk); #1;
    total++; if ({a_ls_rvalid, a_ls_rdata} !== {1'b1, 16'h5A5A}) begin
      bad++; $display("FAIL load_rdata: got %b %h want 1 5a5a", a_ls_rvalid, a_ls_rdata); end
  endtask

  task automatic test_push_pop();
    @(negedge clk); stk_req = 1; stk_pop = 0; stk_wdata = 16'h1234; #1;
    total++; if ({a_stk_gnt, a_stk_err, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata}
                 !== {4'b1011, 32'hFFFE1234}) begin
      bad++; $display("FAIL push_port: got %b %h %h", {a_stk_gnt, a_stk_err, a_mem_en, a_mem_we},
                      a_mem_addr, a_mem_wdata); end
    @(negedge clk); stk_pop = 1; #1;
    total++; if (a_sp !== 16'hFFFE) begin bad++; $display("FAIL push_sp: got %h want fffe", a_sp); end
    total++; if ({a_stk_gnt, a_mem_en, a_mem_we, a_mem_addr} !== {3'b110, 16'hFFFE}) begin
      bad++; $display("FAIL pop_port: got %b %h want 110 fffe", {a_stk_gnt, a_mem_en, a_mem_we}, a_mem_addr); end
    @(negedge clk); stk_req = 0; #1;
    total++; if ({a_sp, a_stk_rvalid} !== {16'hFFFF, 1'b0}) begin
      bad++; $display("FAIL pop_sp: got %h %b want ffff 0", a_sp, a_stk_rvalid); end
    @(negedge clk); #1;
    total++; if ({a_stk_rvalid, a_stk_rdata} !== {1'b1, 16'h1234}) begin
      bad++; $display("FAIL pop_rdata: got %b %h want 1 1234", a_stk_rvalid, a_stk_rdata); end
  endtask

  // Pop on empty stack errors and still takes the slot from a waiting store.
  task automatic test_pop_empty();
    @(negedge clk); stk_req = 1; stk_pop = 1; ls_req = 1; ls_we = 1; ls_addr = 16'h0030; #1;
    total++; if ({a_stk_gnt, a_stk_err, a_mem_en, a_ls_gnt} !== 4'b1100) begin
      bad++; $display("FAIL pop_empty: got %b want 1100", {a_stk_gnt, a_stk_err, a_mem_en, a_ls_gnt}); end
    @(negedge clk); stk_req = 0; ls_req = 0; ls_we = 0; #1;
    total++; if ({a_stk_err, a_sp} !== {1'b0, 16'hFFFF}) begin
      bad++; $display("FAIL pop_empty_sp: got %b %h want 0 ffff", a_stk_err, a_sp); end
    @(negedge clk); #1;
    total++; if (a_stk_rvalid !== 1'b0) begin
      bad++; $display("FAIL pop_empty_rvalid: got %b want 0", a_stk_rvalid); end
  endtask

  task automatic test_overflow();
    int good = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); stk_req = 1; stk_pop = 0; stk_wdata = 16'(i); #1;
      if (a_stk_gnt && !a_stk_err && a_mem_en && a_mem_addr == 16'(16'hFFFE - i)) good++;
    end
    total++; if (good !== 64) begin bad++; $display("FAIL fill_pushes: got %0d want 64", good); end
    @(negedge clk); stk_wdata = 16'hDEAD; #1;
    total++; if ({a_stk_gnt, a_stk_err, a_mem_en, a_sp} !== {3'b110, 16'hFFBF}) begin
      bad++; $display("FAIL overflow: got %b %h want 110 ffbf", {a_stk_gnt, a_stk_err, a_mem_en}, a_sp); end
    @(negedge clk); stk_pop = 1; #1;
    total++; if ({a_sp, a_mem_addr} !== {16'hFFBF, 16'hFFBF}) begin
      bad++; $display("FAIL overflow_sp: got %h %h want ffbf ffbf", a_sp, a_mem_addr); end
    @(negedge clk); stk_req = 0;
    @(negedge clk); #1;
    total++; if ({a_stk_rvalid, a_stk_rdata} !== {1'b1, 16'h003F}) begin
      bad++; $display("FAIL top_pop: got %b %h want 1 003f", a_stk_rvalid, a_stk_rdata); end
  endtask

  task automatic test_priority();
    @(negedge clk); stk_req = 1; stk_pop = 0; stk_wdata = 16'h7777;
    ls_req = 1; ls_we = 1; ls_addr = 16'h0040; if_req = 1; if_addr = 16'h0010; #1;
    total++; if ({a_stk_gnt, a_ls_gnt, a_if_gnt, a_mem_addr} !== {3'b100, 16'hFFBF}) begin
      bad++; $display("FAIL prio_stk: got %b %h want 100 ffbf", {a_stk_gnt, a_ls_gnt, a_if_gnt}, a_mem_addr); end
    @(negedge clk); stk_req = 0; #1;
    total++; if ({a_stk_gnt, a_ls_gnt, a_if_gnt, a_mem_addr} !== {3'b010, 16'h0040}) begin
      bad++; $display("FAIL prio_ls: got %b %h want 010 0040", {a_stk_gnt, a_ls_gnt, a_if_gnt}, a_mem_addr); end
    @(negedge clk); ls_req = 0; ls_we = 0; #1;
    total++; if ({a_stk_gnt, a_ls_gnt, a_if_gnt} !== 3'b001) begin
      bad++; $display("FAIL prio_if: got %b want 001", {a_stk_gnt, a_ls_gnt, a_if_gnt}); end
    @(negedge clk); if_req = 0;
    @(negedge clk); #1;
    total++; if ({a_if_rvalid, a_if_rdata} !== {1'b1, 16'hBEEF}) begin
      bad++; $display("FAIL prio_if_rdata: got %b %h want 1 beef", a_if_rvalid, a_if_rdata); end
  endtask

  // MEM_LAT=1 back-to-back reads with fetch starvation override every 5th slot.
  task automatic test_starvation();
    logic exp_if, prev_if;
    int   errs = 0;
    do_reset();
    prev_if = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); if_req = 1; if_addr = 16'h0010; ls_req = 1; ls_we = 0; ls_addr = 16'h0020; #1;
      exp_if = (k % 5 == 4);
      total++; if ({b_if_gnt, b_ls_gnt} !== {exp_if, ~exp_if}) begin
        bad++; $display("FAIL starve_k%0d: got %b want %b", k, {b_if_gnt, b_ls_gnt}, {exp_if, ~exp_if}); end
      if (k > 0) begin
        if (b_if_rvalid !== prev_if || b_ls_rvalid !== ~prev_if) errs++;
        if (prev_if && b_if_rdata !== 16'hBEEF) errs++;
        if (!prev_if && b_ls_rdata !== 16'h5A5A) errs++;
      end
      prev_if = exp_if;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL b2b_rvalid: got %0d errors want 0", errs); end
    @(negedge clk); idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk); stk_req = 1; stk_pop = 0; stk_wdata = 16'h0001;
    @(negedge clk); stk_req = 0; ls_req = 1; ls_we = 0; ls_addr = 16'h0020; #1;
    total++; if ({a_ls_gnt, a_sp} !== {1'b1, 16'hFFFE}) begin
      bad++; $display("FAIL mid_load_gnt: got %b %h want 1 fffe", a_ls_gnt, a_sp); end
    @(negedge clk); rst_n = 0; #1;
    total++; if ({a_ls_gnt, a_mem_en, a_ls_rvalid, a_mem_addr, a_sp} !== {3'b000, 16'h0, 16'hFFFF}) begin
      bad++; $display("FAIL mid_rst_out: got %b %h %h want 000 0000 ffff",
                      {a_ls_gnt, a_mem_en, a_ls_rvalid}, a_mem_addr, a_sp); end
    @(negedge clk); rst_n = 1; ls_we = 1; ls_addr = 16'h0050; #1;
    total++; if ({a_ls_gnt, a_ls_rvalid, a_mem_en} !== 3'b101) begin
      bad++; $display("FAIL post_rst_gnt: got %b want 101", {a_ls_gnt, a_ls_rvalid, a_mem_en}); end
    @(negedge clk); ls_req = 0; ls_we = 0; #1;
    total++; if ({a_ls_rvalid, a_sp} !== {1'b0, 16'hFFFF}) begin
      bad++; $display("FAIL post_rst_rvalid: got %b %h want 0 ffff", a_ls_rvalid, a_sp); end
  endtask

  initial begin
    test_reset();
    test_store_fetch();
    test_push_pop();
    test_pop_empty();
    test_overflow();
    test_priority();
    test_starvation();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_sequencer.md
# mem_port_sequencer

Shares the single-port data memory of the gpp_calc core between three requesters: instruction fetch, load/store (L/S), and stack push/pop (STACK_PSH/STACK_POP). The block arbitrates by fixed priority with a fetch anti-starvation rule. It sequences multi-cycle reads and owns the stack pointer, including overflow and underflow detection. It sits between the control-unit-driven datapath and the memory macro.

## Interface
- AW, 16, address width
- DW, 16, data width
- MEM_LAT, 1, memory read latency in cycles (legal 1..4)
- STACK_BASE, 16'hFFFF, SP value when the stack is empty
- STACK_DEPTH, 64, maximum number of stack entries
- STARVE_LIM, 4, consecutive lost arbitrations after which fetch is forced to win
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  AW  fetch address (PC)
- if_gnt / if_rvalid  out  1  fetch grant / fetch read data valid
- if_rdata  out  DW  fetch read data
- ls_req, ls_we  in  1  load/store request; ls_we=1 selects store
- ls_addr / ls_wdata  in  AW / DW  load/store address / store data
- ls_gnt / ls_rvalid  out  1  load/store grant / load data valid
- ls_rdata  out  DW  load data
- stk_req, stk_pop  in  1  stack request; stk_pop=0 selects push, 1 selects pop
- stk_wdata  in  DW  push data
- stk_gnt / stk_rvalid / stk_err  out  1  stack grant / pop data valid / error pulse
- stk_rdata  out  DW  popped data
- sp  out  AW  current stack pointer
- mem_en, mem_we  out  1  memory enable / memory write enable
- mem_addr / mem_wdata  out  AW / DW  memory address / memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after a read's mem_en

## Operation
- FSM has two states:
  - IDLE: arbitration is open.
  - BUSY: a read is outstanding; a down-counter is loaded with MEM_LAT-1.
- Arbitration: only in IDLE, or in the final BUSY cycle.
  - Priority is stack > ls > fetch.
  - starve_cnt increments each arbitration cycle in which if_req is high and fetch loses.
  - starve_cnt clears when fetch is granted or if_req is low.
  - When starve_cnt == STARVE_LIM, fetch wins that cycle.
- Grant cycle, combinational:
  - Exactly one *_gnt is high.
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the winner.
- Writes (store, push): complete in the grant cycle. The FSM stays IDLE.
- Reads (fetch, load, pop):
  - Grant moves the FSM to BUSY; the tag of the requester is stored.
  - The matching *_rvalid is high for exactly 1 cycle at grant+MEM_LAT.
  - *_rdata = mem_rdata in that cycle.
  - With MEM_LAT=1 the FSM never leaves IDLE, so back-to-back reads are possible.
- Stack: depth = STACK_BASE - sp, computed modulo 2^AW.
  - Push: mem_addr = sp-1, write stk_wdata, then sp <= sp-1.
  - Pop: mem_addr = sp, read, then sp <= sp+1.
  - Push when depth == STACK_DEPTH: stk_gnt=1, stk_err=1 for 1 cycle, mem_en=0, sp unchanged.
  - Pop when depth == 0: stk_gnt=1, stk_err=1, mem_en=0, sp unchanged, no stk_rvalid, FSM stays IDLE.
- An error grant still consumes the arbitration slot. Lower-priority requesters wait.
- A request deasserted before grant is simply dropped. No grant is owed for it.

## Timing
- Reset values: all *_gnt, *_rvalid, stk_err, mem_en, mem_we = 0; *_rdata = 0; mem_addr and mem_wdata = 0; sp = STACK_BASE; FSM = IDLE; starve_cnt = 0.
- Asserting rst mid-read discards the outstanding read. No rvalid is produced after release.
- First grant is possible in the first clock edge cycle after rst deasserts.
- Read latency: grant at cycle t → rvalid at t+MEM_LAT. A new grant is also possible at t+MEM_LAT.
- No grant occurs in cycles t+1 .. t+MEM_LAT-1.
- Simultaneous events:
  - All three requests at once: stack wins, unless the starvation override is active.
  - When the override fires, stack and ls wait one slot.
- sp updates on the edge ending the grant cycle. The requester sees the new sp the next cycle.
- Address arithmetic wraps modulo 2^AW with no error. Only the depth checks raise stk_err.

## Test plan
- Single fetch, MEM_LAT=2, if_addr=0x0010, memory word 0xBEEF → if_gnt at t, mem_en=1, mem_addr=0x0010; if_rvalid=1 and if_rdata=0xBEEF at t+2; no grant at t+1.
- Push 0x1234, then pop, from reset → push writes 0xFFFE and sp=0xFFFE; pop reads 0xFFFE, stk_rdata=0x1234, sp=0xFFFF.
- Pop on empty stack → stk_gnt=1, stk_err=1 for 1 cycle, mem_en=0, sp stays 0xFFFF, no stk_rvalid.
- 65th push with STACK_DEPTH=64 → stk_err=1, no write, sp stays 0xFFBF.
- if_req and ls_req held high continuously, MEM_LAT=1, STARVE_LIM=4 → 4 ls grants, then 1 fetch grant, repeating.
- rst asserted at t+1 of a MEM_LAT=3 load → all outputs go to 0 immediately; after release no ls_rvalid, sp=0xFFFF, and a new grant is accepted.
